apb_master_arbiter: RTL and testbench

//  Shares one APB requester port between NUM_REQ local clients and sequences the APB SETUP/ACCESS

---
 rtl/apb_master_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB requester port among NUM_REQ clients.
// One transfer in flight: grant, SETUP, ACCESS (with wait states and timeout), response pulse.
module apb_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_strb,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_error,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [ADDR_W-1:0]          PADDR,
  output logic [DATA_W-1:0]          PWDATA,
  output logic [DATA_W/8-1:0]        PSTRB,
  input  logic [DATA_W-1:0]          PRDATA,
  input  logic                       PREADY,
  input  logic                       PERROR
);

  localparam int SW = DATA_W / 8;
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);

  // The state names the phase currently visible on the registered bus outputs.
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                pend_q, pend_d;
  logic [GW-1:0]       last_grant_q, last_grant_d;
  logic [GW-1:0]       gnt_q, gnt_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]       strb_q, strb_d;
  logic [CW-1:0]       wait_cnt_q, wait_cnt_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_error_q, rsp_error_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;

  logic                any_valid;
  logic [GW-1:0]       gnt_idx;
  logic                finish;

  // Round-robin scan starting just after the last granted client.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    any_valid = 1'b0;
    gnt_idx   = last_grant_q;
    for (int off = 1; off <= NUM_REQ; off++) begin
      logic [GW-1:0] idx;
      idx = GW'((int'(last_grant_q) + off) % NUM_REQ);
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    wait_cnt_d   = wait_cnt_q;
    req_ready_d  = '0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = '0;
    rsp_error_d  = 1'b0;
    psel_d       = 1'b0;
    penable_d    = 1'b0;
    finish       = 1'b0;

    // Arbitration also runs in RESP so a new grant overlaps the response cycle.
    if (((state_q == S_IDLE && !pend_q) || state_q == S_RESP) && any_valid) begin
      req_ready_d[gnt_idx] = 1'b1;
      last_grant_d         = gnt_idx;
      gnt_d                = gnt_idx;
      write_d              = req_write[gnt_idx];
      addr_d               = req_addr[gnt_idx*ADDR_W +: ADDR_W];
      wdata_d              = req_wdata[gnt_idx*DATA_W +: DATA_W];
      strb_d               = req_write[gnt_idx] ? req_strb[gnt_idx*SW +: SW] : '0;
      pend_d               = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d = S_SETUP;
          pend_d  = 1'b0;
          psel_d  = 1'b1;
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      S_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        if (PREADY) begin
          finish      = 1'b1;
          rsp_rdata_d = write_q ? '0 : PRDATA;
          rsp_error_d = PERROR;
        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          finish      = 1'b1;
          rsp_error_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
        if (finish) begin
          state_d              = S_RESP;
          psel_d               = 1'b0;
          penable_d            = 1'b0;
          rsp_valid_d[gnt_q]   = 1'b1;
          wait_cnt_d           = '0;
        end
      end
      S_RESP: begin
        state_d    = S_IDLE;
        wait_cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q      <= S_IDLE;
      pend_q       <= 1'b0;
      last_grant_q <= GW'(NUM_REQ - 1);
      gnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      wait_cnt_q   <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_error_q  <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      pend_q       <= pend_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      wait_cnt_q   <= wait_cnt_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_error_q  <= rsp_error_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = write_q;
  assign PADDR     = addr_q;
  assign PWDATA    = wdata_q;
  assign PSTRB     = strb_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed transfers, a behavioural completer,
// and a response scoreboard filled when requests are issued.
module tb_apb_master_arbiter;

  typedef logic [63:0] u64;

  typedef struct {
    int          client;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        PCLK;
  logic        PRESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_strb;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PERROR;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t exp_e;

  // Completer behaviour knobs
  int          cfg_wait = 0;
  logic        cfg_hang = 1'b0;
  logic        cfg_perr = 1'b0;
  logic [31:0] cfg_rdata = 32'hCAFE_F00D;
  int          acc_k = 0;

  apb_master_arbiter #(
    .NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PERROR(PERROR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input u64 got, input u64 exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge PCLK);
  endtask

  // Completer: PREADY rises after cfg_wait ACCESS cycles unless hung.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      PREADY = !cfg_hang && (acc_k >= cfg_wait);
      PERROR = PREADY && cfg_perr;
      PRDATA = PREADY ? cfg_rdata : 32'hBAD0_BAD0;
      acc_k  = acc_k + 1;
    end else begin
      PREADY = 1'b0;
      PERROR = 1'b0;
      PRDATA = '0;
      acc_k  = 0;
    end
  end

  // Response monitor: pops the scoreboard on every rsp_valid pulse.
  always @(negedge PCLK) begin
    if (!PRESET && rsp_valid != '0) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", u64'(rsp_valid), u64'(0));
      end else begin
        exp_e = sb.pop_front();
        check("rsp_valid", u64'(rsp_valid), u64'(2'b01 << exp_e.client));
        check("rsp_rdata", u64'(rsp_rdata), u64'(exp_e.rdata));
        check("rsp_error", u64'(rsp_error), u64'(exp_e.err));
      end
    end
  end

  task automatic push_exp(input int c, input logic [31:0] rd, input logic er);
    exp_t e;
    e.client = c;
    e.rdata  = rd;
    e.err    = er;
    sb.push_back(e);
  endtask

  task automatic set_req(input int c, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_write[c]          = wr;
    req_addr[c*32 +: 32]  = a;
    req_wdata[c*32 +: 32] = d;
    req_strb[c*4 +: 4]    = s;
    req_valid[c]          = 1'b1;
  endtask

  // Raise valid, wait (bounded) for the ready pulse, then drop valid.
  task automatic issue(input int c, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    bit seen;
    seen = 1'b0;
    set_req(c, wr, a, d, s);
    for (int i = 0; i < 40; i++) begin
      step();
      if (req_ready[c]) begin
        seen = 1'b1;
        break;
      end
    end
    check("issue_ready", u64'(seen), u64'(1));
    req_valid[c] = 1'b0;
  endtask

  // Count ACCESS cycles until the response, checking PADDR stays put.
  task automatic run_access(input string tag, input logic [31:0] addr, output int acc);
    acc = 0;
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid != '0) break;
      if (PSEL && PENABLE) begin
        acc++;
        check({tag, "_paddr"}, u64'(PADDR), u64'(addr));
      end
      step();
    end
    check({tag, "_rsp_seen"}, u64'(rsp_valid != '0), u64'(1));
    check({tag, "_psel_drop"}, u64'(PSEL), u64'(0));
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    check("sb_drain", u64'(sb.size()), u64'(0));
  endtask

  initial begin
    int acc;
    int prev;
    bit got;

    PRESET    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_strb  = '0;
    PREADY    = 1'b0;
    PERROR    = 1'b0;
    PRDATA    = '0;
    repeat (3) step();

    check("rst_req_ready", u64'(req_ready), u64'(0));
    check("rst_rsp_valid", u64'(rsp_valid), u64'(0));
    check("rst_psel", u64'(PSEL), u64'(0));
    check("rst_penable", u64'(PENABLE), u64'(0));
    check("rst_paddr", u64'(PADDR), u64'(0));
    check("rst_pstrb", u64'(PSTRB), u64'(0));
    PRESET = 1'b0;
    step();

    // 1: single write, cycle-exact phase timing
    cfg_wait = 0;
    push_exp(0, 32'h0, 1'b0);
    set_req(0, 1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF);
    step();
    check("t1_ready", u64'(req_ready), u64'(2'b01));
    check("t1_psel_c0", u64'(PSEL), u64'(0));
    req_valid = '0;
    step();
    check("t1_psel_c1", u64'(PSEL), u64'(1));
    check("t1_penable_c1", u64'(PENABLE), u64'(0));
    check("t1_paddr", u64'(PADDR), u64'(32'h4));
    check("t1_pwrite", u64'(PWRITE), u64'(1));
    check("t1_pwdata", u64'(PWDATA), u64'(32'hDEAD_BEEF));
    check("t1_pstrb", u64'(PSTRB), u64'(4'hF));
    step();
    check("t1_psel_c2", u64'(PSEL), u64'(1));
    check("t1_penable_c2", u64'(PENABLE), u64'(1));
    step();
    check("t1_rsp_c3", u64'(rsp_valid), u64'(2'b01));
    check("t1_psel_c3", u64'(PSEL), u64'(0));
    drain();

    // 3: read with three wait states
    cfg_wait  = 3;
    cfg_rdata = 32'h1234_5678;
    push_exp(1, 32'h1234_5678, 1'b0);
    issue(1, 1'b0, 32'h8, 32'h0, 4'hF);
    step();
    check("t3_pstrb_read", u64'(PSTRB), u64'(0));
    check("t3_pwrite", u64'(PWRITE), u64'(0));
    run_access("t3", 32'h8, acc);
    check("t3_access_len", u64'(acc), u64'(4));
    drain();

    // 2: both clients valid continuously -> alternating grants every 4 cycles
    cfg_wait  = 0;
    cfg_rdata = 32'hCAFE_F00D;
    for (int g = 0; g < 4; g++) push_exp(g % 2, 32'h0, 1'b0);
    set_req(0, 1'b1, 32'h10, 32'h1111_0000, 4'h3);
    set_req(1, 1'b1, 32'h20, 32'h2222_0000, 4'hC);
    prev = 0;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (req_ready != '0) begin
          got = 1'b1;
          break;
        end
      end
      check("t2_grant_seen", u64'(got), u64'(1));
      check("t2_grant", u64'(req_ready), u64'((g % 2) ? 2'b10 : 2'b01));
      if (g > 0) check("t2_spacing", u64'(cyc - prev), u64'(4));
      prev = cyc;
      if (g == 3) req_valid = '0;
    end
    drain();

    // 4: completer never ready -> timeout abort after 16 ACCESS cycles
    cfg_hang  = 1'b1;
    cfg_rdata = 32'hA5A5_A5A5;
    push_exp(0, 32'h0, 1'b1);
    issue(0, 1'b0, 32'hC, 32'h0, 4'h0);
    run_access("t4", 32'hC, acc);
    check("t4_access_len", u64'(acc), u64'(16));
    cfg_hang = 1'b0;
    drain();

    // 5: PERROR on a write, then a clean transfer
    cfg_perr = 1'b1;
    push_exp(0, 32'h0, 1'b1);
    issue(0, 1'b1, 32'h40, 32'h5555_AAAA, 4'hF);
    run_access("t5a", 32'h40, acc);
    check("t5a_access_len", u64'(acc), u64'(1));
    cfg_perr = 1'b0;
    drain();
    push_exp(1, 32'h0, 1'b0);
    issue(1, 1'b1, 32'h44, 32'h0BAD_CAFE, 4'h1);
    run_access("t5b", 32'h44, acc);
    drain();

    // 6: reset in the middle of ACCESS
    cfg_hang = 1'b1;
    issue(0, 1'b0, 32'h30, 32'h0, 4'h0);
    for (int i = 0; i < 10; i++) begin
      if (PSEL && PENABLE) break;
      step();
    end
    check("t6_in_access", u64'(PSEL && PENABLE), u64'(1));
    PRESET = 1'b1;
    #1;
    check("t6_psel", u64'(PSEL), u64'(0));
    check("t6_penable", u64'(PENABLE), u64'(0));
    check("t6_req_ready", u64'(req_ready), u64'(0));
    check("t6_rsp_valid", u64'(rsp_valid), u64'(0));
    cfg_hang = 1'b0;
    set_req(0, 1'b1, 32'h50, 32'h6666_0000, 4'hF);
    set_req(1, 1'b1, 32'h54, 32'h7777_0000, 4'hF);
    step();
    step();
    push_exp(0, 32'h0, 1'b0);
    PRESET = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (req_ready != '0) begin
        got = 1'b1;
        break;
      end
    end
    check("t6_grant_seen", u64'(got), u64'(1));
    check("t6_first_grant", u64'(req_ready), u64'(2'b01));
    req_valid = '0;
    drain();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
